// File: rtl/conv_mac_pipe.sv
// One K x K convolution window per job: LANES multiplies per beat, then bias, shift, ReLU, saturate.
// Result first valid BEATS+2 cycles after the acceptance cycle; it holds until out_ready, with no new job accepted meanwhile.
module conv_mac_pipe #(
    parameter int FILTER_SIZE = 3,
    parameter int DATA_W      = 8,
    parameter int COEF_W      = 8,
    parameter int LANES       = 3,
    parameter int ACC_W       = 32,
    parameter int OUT_W       = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [FILTER_SIZE*FILTER_SIZE*DATA_W-1:0]  window_in,
    input  logic [FILTER_SIZE*FILTER_SIZE*COEF_W-1:0]  filter_flat,
    input  logic [ACC_W-1:0]                           bias,
    input  logic [4:0]                                 shift_amt,
    input  logic                                       relu_en,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [OUT_W-1:0]                           result,
    output logic                                       sat_flag,
    output logic                                       busy
);

    localparam int NTAP   = FILTER_SIZE * FILTER_SIZE;
    localparam int BEATS  = (NTAP + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] POST   = 2'd2;
    localparam logic [1:0] OUTPUT = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    logic [1:0]                          state;
    logic [BEAT_W-1:0]                   beat;
    logic signed [ACC_W-1:0]             acc;
    logic [NTAP*DATA_W-1:0]              win_q;
    logic [NTAP*COEF_W-1:0]              filt_q;
    logic signed [ACC_W-1:0]             bias_q;
    logic [4:0]                          shift_q;
    logic                                relu_q;

    int                                  beat_base;
    logic signed [ACC_W-1:0]             px;
    logic signed [ACC_W-1:0]             cf;
    logic signed [ACC_W-1:0]             lane_sum;

    logic signed [ACC_W-1:0]             biased;
    logic signed [ACC_W-1:0]             shifted;
    logic signed [ACC_W-1:0]             post_v;
    logic [OUT_W-1:0]                    sat_res;
    logic                                sat_hit;

    assign in_ready = rst && (state == IDLE);
    assign busy     = rst && (state != IDLE);

    // Pixels zero-extend, coefficients sign-extend; taps past the last window element add nothing.
    always_comb begin
        beat_base = int'(beat) * LANES;
        lane_sum  = '0;
        px        = '0;
        cf        = '0;
        for (int l = 0; l < LANES; l++) begin
            if (beat_base + l < NTAP) begin
                px       = ACC_W'(win_q[(beat_base + l)*DATA_W +: DATA_W]);
                cf       = ACC_W'($signed(filt_q[(beat_base + l)*COEF_W +: COEF_W]));
                lane_sum = lane_sum + px * cf;
            end
        end
    end

    always_comb begin
        biased  = acc + bias_q;
        shifted = biased >>> shift_q;
        post_v  = (relu_q && shifted < 0) ? '0 : shifted;
        sat_hit = 1'b0;
        sat_res = OUT_W'(post_v);
        if (post_v > SAT_MAX) begin
            sat_res = OUT_W'(SAT_MAX);
            sat_hit = 1'b1;
        end else if (post_v < SAT_MIN) begin
            sat_res = OUT_W'(SAT_MIN);
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            beat      <= '0;
            result    <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        win_q   <= window_in;
                        filt_q  <= filter_flat;
                        bias_q  <= bias;
                        shift_q <= shift_amt;
                        relu_q  <= relu_en;
                        acc     <= '0;
                        beat    <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + lane_sum;
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        state <= POST;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                POST: begin
                    result    <= sat_res;
                    sat_flag  <= sat_hit;
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Three DUTs (LANES 3, 1, 9) on shared data buses; expected results queued when a job is driven.
module tb_conv_mac_pipe;

    typedef struct {
        logic [15:0] res;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [71:0] w;
        logic [71:0] f;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        r;
    } job_t;

    logic        clk;
    logic        rst;
    logic [71:0] window_in;
    logic [71:0] filter_flat;
    logic [31:0] bias;
    logic [4:0]  shift_amt;
    logic        relu_en;

    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] result    [3];
    logic        sat_flag  [3];
    logic        busy      [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   lat_exp [3] = '{5, 11, 3};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LN = (g == 0) ? 3 : (g == 1) ? 1 : 9;
        conv_mac_pipe #(
            .FILTER_SIZE(3), .DATA_W(8), .COEF_W(8), .LANES(LN), .ACC_W(32), .OUT_W(16)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .window_in  (window_in),
            .filter_flat(filter_flat),
            .bias       (bias),
            .shift_amt  (shift_amt),
            .relu_en    (relu_en),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .result     (result[g]),
            .sat_flag   (sat_flag[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input job_t j);
        int   acc;
        int   v;
        exp_t e;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            acc += int'(j.w[i*8 +: 8]) * int'($signed(j.f[i*8 +: 8]));
        end
        v = (acc + int'($signed(j.b))) >>> j.sh;
        if (j.r && v < 0) v = 0;
        if (v > 32767) begin
            e.res = 16'h7fff; e.sat = 1'b1;
        end else if (v < -32768) begin
            e.res = 16'h8000; e.sat = 1'b1;
        end else begin
            e.res = v[15:0];  e.sat = 1'b0;
        end
        return e;
    endfunction

    function automatic job_t mk(input logic [7:0] wv, input logic [7:0] fv, input int b,
                                input int sh, input logic r);
        job_t j;
        j.w = {9{wv}}; j.f = {9{fv}}; j.b = b; j.sh = 5'(sh); j.r = r;
        return j;
    endfunction

    function automatic job_t rnd_job();
        job_t j;
        for (int i = 0; i < 9; i++) begin
            j.w[i*8 +: 8] = 8'($urandom);
            j.f[i*8 +: 8] = 8'($urandom);
        end
        j.b  = 32'($urandom_range(0, 4000)) - 32'd2000;
        j.sh = 5'($urandom_range(0, 6));
        j.r  = 1'($urandom);
        return j;
    endfunction

    task automatic scramble();
        for (int i = 0; i < 9; i++) begin
            window_in[i*8 +: 8]   = 8'($urandom);
            filter_flat[i*8 +: 8] = 8'($urandom);
        end
        bias      = $urandom;
        shift_amt = 5'($urandom);
        relu_en   = 1'($urandom);
    endtask

    // Presents a job, queues its expectation, returns #1 after the acceptance edge.
    task automatic send(input int d, input job_t j, input exp_t e);
        window_in = j.w; filter_flat = j.f; bias = j.b; shift_amt = j.sh; relu_en = j.r;
        in_valid[d] = 1'b1;
        sb.push_back(e);
        for (int k = 0; k < 50 && !in_ready[d]; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        scramble();
    endtask

    task automatic wait_valid(input int d, output int cyc);
        cyc = 1;
        while (!out_valid[d] && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (in_ready[d] !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready[%0d] got %b want 0", d, in_ready[d]); end
            n_tests++; if (busy[d] !== 1'b0)      begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", d, busy[d]); end
            n_tests++; if (out_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got %b want 0", d, out_valid[d]); end
            n_tests++; if (result[d] !== 16'd0)   begin n_fail++; $display("FAIL reset_result[%0d] got %h want 0", d, result[d]); end
            n_tests++; if (sat_flag[d] !== 1'b0)  begin n_fail++; $display("FAIL reset_sat[%0d] got %b want 0", d, sat_flag[d]); end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready[%0d] got %b want 1", d, in_ready[d]); end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   cyc;
        send(0, mk(8'd1, 8'd2, 0, 0, 1'b0), '{16'd18, 1'b0});
        n_tests++; if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy got rdy=%b busy=%b want 0/1", in_ready[0], busy[0]); end
        wait_valid(0, cyc);
        n_tests++; if (cyc !== 5 || out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %0d valid=%b want 5", cyc, out_valid[0]); end
        e = sb.pop_front();
        n_tests++; if (result[0] !== e.res)  begin n_fail++; $display("FAIL basic_result got %0d want %0d", $signed(result[0]), $signed(e.res)); end
        n_tests++; if (sat_flag[0] !== e.sat) begin n_fail++; $display("FAIL basic_sat got %b want %b", sat_flag[0], e.sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed_shift_sat();
        job_t jt [6];
        exp_t et [6];
        exp_t e;
        int   cyc;
        jt[0] = mk(8'd10, 8'hff, 5, 0, 1'b0);   et[0] = '{16'hffab, 1'b0};
        jt[1] = mk(8'd10, 8'hff, 5, 0, 1'b1);   et[1] = '{16'd0, 1'b0};
        jt[2] = mk(8'd0, 8'hff, 0, 1, 1'b0);    jt[2].w[39:32] = 8'd7; et[2] = '{16'hfffc, 1'b0};
        jt[3] = mk(8'd255, 8'h7f, 0, 0, 1'b0);  et[3] = '{16'h7fff, 1'b1};
        jt[4] = mk(8'd255, 8'h80, 0, 0, 1'b0);  et[4] = '{16'h8000, 1'b1};
        jt[5] = mk(8'd2, 8'd3, 100, 2, 1'b0);   et[5] = '{16'd38, 1'b0};
        for (int i = 0; i < 6; i++) begin
            send(0, jt[i], et[i]);
            wait_valid(0, cyc);
            e = sb.pop_front();
            n_tests++; if (out_valid[0] !== 1'b1 || result[0] !== e.res) begin n_fail++; $display("FAIL sign_sat_result[%0d] got %0d want %0d", i, $signed(result[0]), $signed(e.res)); end
            n_tests++; if (sat_flag[0] !== e.sat) begin n_fail++; $display("FAIL sign_sat_flag[%0d] got %b want %b", i, sat_flag[0], e.sat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        int   bad;
        int   extra;
        out_ready[0] = 1'b0;
        send(0, mk(8'd3, 8'd5, -100, 0, 1'b0), '{16'd35, 1'b0});
        wait_valid(0, cyc);
        e   = sb.pop_front();
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid[0] !== 1'b1 || result[0] !== e.res || sat_flag[0] !== e.sat || in_ready[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        n_tests++; if (out_valid[0] !== 1'b1 || result[0] !== e.res) begin n_fail++; $display("FAIL bp_result got %0d want %0d", $signed(result[0]), $signed(e.res)); end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release got valid=%b rdy=%b want 0/1", out_valid[0], in_ready[0]); end
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) extra++;
        end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL bp_single_transfer got %0d extra want 0", extra); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        job_t jb;
        int   cyc;
        int   leak;
        send(0, mk(8'd1, 8'd2, 0, 0, 1'b0), model(mk(8'd1, 8'd2, 0, 0, 1'b0)));
        jb = mk(8'd4, 8'hfd, 7, 1, 1'b0);
        window_in = jb.w; filter_flat = jb.f; bias = jb.b; shift_amt = jb.sh; relu_en = jb.r;
        in_valid[0] = 1'b1;
        sb.push_back(model(jb));
        leak = 0;
        cyc  = 1;
        while (!out_valid[0] && cyc < 60) begin
            if (in_ready[0] !== 1'b0) leak++;
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++; if (leak !== 0 || cyc !== 5) begin n_fail++; $display("FAIL b2b_first got leak=%0d lat=%0d want 0/5", leak, cyc); end
        e = sb.pop_front();
        n_tests++; if (result[0] !== e.res) begin n_fail++; $display("FAIL b2b_first_result got %0d want %0d", $signed(result[0]), $signed(e.res)); end
        @(posedge clk); #1;
        n_tests++; if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got rdy=%b valid=%b want 1/0", in_ready[0], out_valid[0]); end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        scramble();
        wait_valid(0, cyc);
        e = sb.pop_front();
        n_tests++; if (cyc !== 5 || result[0] !== e.res) begin n_fail++; $display("FAIL b2b_second got %0d lat=%0d want %0d lat=5", $signed(result[0]), cyc, $signed(e.res)); end
        @(posedge clk); #1;
        leak = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) leak++;
        end
        n_tests++; if (leak !== 0) begin n_fail++; $display("FAIL b2b_no_double got %0d want 0", leak); end
    endtask

    task automatic test_lanes();
        job_t j;
        exp_t e;
        int   cyc;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 5; i++) begin
                if (i == 0) begin
                    j = mk(8'd1, 8'd2, 0, 0, 1'b0);
                    e = '{16'd18, 1'b0};
                end else if (i == 1) begin
                    j = mk(8'd10, 8'hff, 5, 0, 1'b0);
                    e = '{16'hffab, 1'b0};
                end else begin
                    j = rnd_job();
                    e = model(j);
                end
                send(d, j, e);
                wait_valid(d, cyc);
                e = sb.pop_front();
                n_tests++; if (cyc !== lat_exp[d]) begin n_fail++; $display("FAIL lanes_latency[%0d.%0d] got %0d want %0d", d, i, cyc, lat_exp[d]); end
                n_tests++; if (result[d] !== e.res || sat_flag[d] !== e.sat) begin n_fail++; $display("FAIL lanes_result[%0d.%0d] got %0d/%b want %0d/%b", d, i, $signed(result[d]), sat_flag[d], $signed(e.res), e.sat); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_accum();
        exp_t e;
        int   seen;
        send(1, mk(8'd9, 8'd9, 0, 0, 1'b0), '{16'd729, 1'b0});
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready[1] !== 1'b0 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_low got rdy=%b busy=%b want 0/0", in_ready[1], busy[1]); end
        @(posedge clk); #1;
        rst  = 1'b1;
        seen = 0;
        repeat (15) begin
            if (out_valid[1] !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mid_rst_no_output got %0d valid cycles want 0", seen); end
        n_tests++; if (result[1] !== 16'd0 || sat_flag[1] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cleared got %h/%b want 0/0", result[1], sat_flag[1]); end
        n_tests++; if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle got rdy=%b busy=%b want 1/0", in_ready[1], busy[1]); end
        send(1, mk(8'd1, 8'd2, 0, 0, 1'b0), '{16'd18, 1'b0});
        wait_valid(1, seen);
        e = sb.pop_front();
        n_tests++; if (seen !== 11 || result[1] !== e.res) begin n_fail++; $display("FAIL mid_rst_recover got %0d lat=%0d want %0d lat=11", $signed(result[1]), seen, $signed(e.res)); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        scramble();
        test_reset();
        test_basic();
        test_signed_shift_sat();
        test_backpressure();
        test_back_to_back();
        test_lanes();
        test_reset_mid_accum();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
